// File: rtl/mips32_pkg.sv
// Shared constants for the MIPS32 boot path: halt word, opcodes and loader states.
// No logic; imported by the loader and its watchdog.
package mips32_pkg;

    localparam logic [31:0] HLT_WORD = 32'hfc000000;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h0a;
    localparam logic [5:0] OP_HLT  = 6'h3f;

    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_PAD  = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } ldr_state_t;

endpackage

// File: rtl/mips32_run_watchdog.sv
// Counts cycles spent in RUN and flags the last permitted cycle.
// Zero-latency timeout flag; clr has priority over en, no backpressure.
module mips32_run_watchdog
    import mips32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = en && (count == LAST);

endmodule

// File: rtl/mips32_prog_loader.sv
// Streams a program into core memory from address 0, forces a trailing HLT, then
// releases the core and watches HALTED. Writes land one cycle after acceptance;
// s_ready is registered and low outside LOAD or once memory is full.
module mips32_prog_loader #(
    parameter int          ADDR_W         = 10,
    parameter int          MAX_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] HLT_WORD       = mips32_pkg::HLT_WORD
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    input  logic              core_halted,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              error
);
    import mips32_pkg::*;

    localparam logic [ADDR_W:0] CAP = (ADDR_W + 1)'(MAX_WORDS);

    ldr_state_t      state;
    logic [ADDR_W:0] addr;
    logic [ADDR_W:0] addr_inc;
    logic            accept;
    logic            in_cap;
    logic            timeout;

    assign accept   = s_valid && s_ready;
    assign addr_inc = addr + 1'b1;
    assign in_cap   = addr < CAP;

    mips32_run_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk1    (clk1),
        .rst_n   (rst_n),
        .clr     (state != ST_RUN),
        .en      (state == ST_RUN),
        .timeout (timeout)
    );

    // The write strobe trails acceptance by one cycle, so the final word's
    // write coincides with the first RUN cycle and completes on that edge.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LOAD;
            addr       <= '0;
            word_count <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            s_ready    <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            s_ready <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= addr[ADDR_W-1:0];
                        mem_wdata  <= s_data;
                        addr       <= addr_inc;
                        word_count <= word_count + 1'b1;
                        if (s_last) begin
                            state <= (s_data == HLT_WORD) ? ST_RUN : ST_PAD;
                        end else begin
                            s_ready <= addr_inc < CAP;
                        end
                    end else if (!in_cap) begin
                        state <= ST_ERR;
                    end else begin
                        s_ready <= 1'b1;
                    end
                end
                ST_PAD: begin
                    if (in_cap) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= addr[ADDR_W-1:0];
                        mem_wdata  <= HLT_WORD;
                        addr       <= addr_inc;
                        word_count <= word_count + 1'b1;
                        state      <= ST_RUN;
                    end else begin
                        state <= ST_ERR;
                    end
                end
                ST_RUN: begin
                    if (core_halted) begin
                        state <= ST_DONE;
                    end else if (timeout) begin
                        state <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        addr       <= '0;
                        word_count <= '0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // DONE keeps the core out of reset so its register file stays readable.
    assign core_rst_n = (state == ST_RUN) || (state == ST_DONE);
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERR);

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed checks of the program loader: two instances, one roomy (16 words) and one
// tiny (4 words) for overflow cases; both use a 16-cycle run timeout.
module tb_mips32_prog_loader;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst_n, start_a, start_b, s_valid_a, s_valid_b, s_last;
    logic [31:0] s_data;
    logic        core_halted_a, core_halted_b;

    logic        s_ready_a, mem_we_a, core_rst_n_a, done_a, error_a;
    logic [3:0]  mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [4:0]  word_count_a;

    logic        s_ready_b, mem_we_b, core_rst_n_b, done_b, error_b;
    logic [1:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [2:0]  word_count_b;

    mips32_prog_loader #(.ADDR_W(4), .MAX_WORDS(16), .TIMEOUT_CYCLES(16)) dut_a (
        .clk1(clk1), .rst_n(rst_n), .start(start_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
        .s_data(s_data), .s_last(s_last), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .core_rst_n(core_rst_n_a), .core_halted(core_halted_a),
        .word_count(word_count_a), .done(done_a), .error(error_a)
    );

    mips32_prog_loader #(.ADDR_W(2), .MAX_WORDS(4), .TIMEOUT_CYCLES(16)) dut_b (
        .clk1(clk1), .rst_n(rst_n), .start(start_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .s_data(s_data), .s_last(s_last), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .core_rst_n(core_rst_n_b), .core_halted(core_halted_b),
        .word_count(word_count_b), .done(done_b), .error(error_b)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, nwr_a = 0, nwr_b = 0, viol = 0;
    logic [31:0] la_addr [64];
    logic [31:0] la_data [64];
    int          la_cyc  [64];

    // Write log sampled mid-cycle; every write strobe lasts exactly one cycle.
    always @(negedge clk1) begin
        cyc <= cyc + 1;
        if (mem_we_a && nwr_a < 64) begin
            la_addr[nwr_a] <= 32'(mem_addr_a);
            la_data[nwr_a] <= mem_wdata_a;
            la_cyc[nwr_a]  <= cyc;
            nwr_a          <= nwr_a + 1;
        end
        if (mem_we_b) nwr_b <= nwr_b + 1;
        if ((done_a && error_a) || (done_b && error_b)) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input int sel, input logic [31:0] d, input logic l);
        int n = 0;
        s_data = d;
        s_last = l;
        if (sel == 0) s_valid_a = 1'b1; else s_valid_b = 1'b1;
        while (!((sel == 0) ? s_ready_a : s_ready_b) && n < 40) begin
            @(negedge clk1);
            n++;
        end
        if (n >= 40) begin
            n_chk++;
            n_fail++;
            $error("FAIL send_wait observed=s_ready_low expected=accept_within_40");
        end
        @(negedge clk1);
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
        s_last    = 1'b0;
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                              32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                              32'hfc000000};
    logic [31:0] gw [6] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                            32'h55555555, 32'hfc000000};

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; s_valid_a = 1'b0; s_valid_b = 1'b0;
        s_last = 1'b0; s_data = '0; core_halted_a = 1'b0; core_halted_b = 1'b0;

        #12;
        chk("rst_s_ready", 32'(s_ready_a), 0);
        chk("rst_mem_we", 32'(mem_we_a), 0);
        chk("rst_mem_addr", 32'(mem_addr_a), 0);
        chk("rst_mem_wdata", mem_wdata_a, 0);
        chk("rst_core_rst_n", 32'(core_rst_n_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_error", 32'(error_a), 0);
        chk("rst_word_count", 32'(word_count_a), 0);

        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
        chk("ready_after_reset", 32'(s_ready_a), 1);

        // Nine-word program ending in HLT, back to back.
        base = nwr_a;
        for (int i = 0; i < 9; i++) send(0, prog[i], i == 8);
        #1;
        chk("prog_nwrites", 32'(nwr_a - base), 9);
        for (int i = 0; i < 9; i++) begin
            chk("prog_addr", la_addr[base+i], 32'(i));
            chk("prog_data", la_data[base+i], prog[i]);
        end
        chk("prog_b2b_span", 32'(la_cyc[base+8] - la_cyc[base]), 8);
        chk("prog_word_count", 32'(word_count_a), 9);
        chk("prog_core_released", 32'(core_rst_n_a), 1);
        chk("prog_ready_low", 32'(s_ready_a), 0);
        @(negedge clk1);
        core_halted_a = 1'b1;
        @(negedge clk1);
        core_halted_a = 1'b0;
        chk("halt_done", 32'(done_a), 1);
        chk("halt_error", 32'(error_a), 0);
        chk("halt_core_rst_n", 32'(core_rst_n_a), 1);

        pulse_start(0);
        chk("start_done_clr", 32'(done_a), 0);
        chk("start_wc_clr", 32'(word_count_a), 0);
        chk("start_core_hold", 32'(core_rst_n_a), 0);
        chk("start_ready_low", 32'(s_ready_a), 0);
        @(negedge clk1);
        chk("start_ready_rise", 32'(s_ready_a), 1);

        // Program without HLT gets a pad, then times out with no halt.
        base = nwr_a;
        send(0, 32'h2801000a, 1'b0);
        send(0, 32'h28020014, 1'b0);
        send(0, 32'h28030019, 1'b1);
        @(negedge clk1);
        #1;
        chk("pad_nwrites", 32'(nwr_a - base), 4);
        chk("pad_addr", la_addr[base+3], 3);
        chk("pad_data", la_data[base+3], 32'hfc000000);
        chk("pad_word_count", 32'(word_count_a), 4);
        chk("pad_core_released", 32'(core_rst_n_a), 1);
        repeat (15) @(negedge clk1);
        chk("timeout_not_yet", 32'(error_a), 0);
        @(negedge clk1);
        chk("timeout_error", 32'(error_a), 1);
        chk("timeout_core_hold", 32'(core_rst_n_a), 0);
        chk("timeout_done", 32'(done_a), 0);
        pulse_start(0);
        chk("restart_error_clr", 32'(error_a), 0);
        chk("restart_wc", 32'(word_count_a), 0);
        @(negedge clk1);

        // Gapped stream: writes stay contiguous and the strobe idles in gaps.
        base = nwr_a;
        for (int i = 0; i < 6; i++) begin
            send(0, gw[i], i == 5);
            if (i < 5) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk1);
                    chk("gap_mem_we", 32'(mem_we_a), 0);
                end
            end
        end
        #1;
        chk("gap_nwrites", 32'(nwr_a - base), 6);
        for (int i = 0; i < 6; i++) begin
            chk("gap_addr", la_addr[base+i], 32'(i));
            chk("gap_data", la_data[base+i], gw[i]);
        end
        @(negedge clk1);
        core_halted_a = 1'b1;
        @(negedge clk1);
        core_halted_a = 1'b0;
        chk("gap_done", 32'(done_a), 1);

        // Overflow on the 4-word instance.
        base = nwr_b;
        for (int i = 0; i < 4; i++) send(1, 32'h28010000 + 32'(i), 1'b0);
        chk("ovf_ready_low", 32'(s_ready_b), 0);
        chk("ovf_wc", 32'(word_count_b), 4);
        s_data = 32'h99999999;
        s_valid_b = 1'b1;
        @(negedge clk1);
        chk("ovf_error", 32'(error_b), 1);
        repeat (3) @(negedge clk1);
        s_valid_b = 1'b0;
        chk("ovf_wc_hold", 32'(word_count_b), 4);
        chk("ovf_nwrites", 32'(nwr_b - base), 4);
        chk("ovf_ready_stays_low", 32'(s_ready_b), 0);

        // Full memory with non-HLT last word: no room for a pad.
        pulse_start(1);
        chk("b_restart_error_clr", 32'(error_b), 0);
        @(negedge clk1);
        base = nwr_b;
        for (int i = 0; i < 4; i++) send(1, 32'h00222000, i == 3);
        @(negedge clk1);
        #1;
        chk("nopad_error", 32'(error_b), 1);
        chk("nopad_nwrites", 32'(nwr_b - base), 4);
        chk("nopad_wc", 32'(word_count_b), 4);
        chk("nopad_core_hold", 32'(core_rst_n_b), 0);

        // Asynchronous reset in the middle of a load.
        pulse_start(0);
        @(negedge clk1);
        send(0, prog[0], 1'b0);
        send(0, prog[1], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s_ready", 32'(s_ready_a), 0);
        chk("arst_mem_we", 32'(mem_we_a), 0);
        chk("arst_mem_addr", 32'(mem_addr_a), 0);
        chk("arst_mem_wdata", mem_wdata_a, 0);
        chk("arst_word_count", 32'(word_count_a), 0);
        chk("arst_core_rst_n", 32'(core_rst_n_a), 0);
        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
        base = nwr_a;
        for (int i = 0; i < 9; i++) send(0, prog[i], i == 8);
        #1;
        chk("reload_first_addr", la_addr[base], 0);
        chk("reload_last_addr", la_addr[base+8], 8);
        chk("reload_word_count", 32'(word_count_a), 9);

        chk("done_error_exclusive", 32'(viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
